udp_rx_payload_checker: RTL and testbench

// Sink on the UDP_10G_Stack user RX AXIS port (m_axis_user_*). It checks each received UDP payload against
// the rolling byte pattern that the TX-side AXIS test source produces. It also checks the tuser length,
// the tkeep framing and the inter-beat gaps. It keeps saturating statistics for loopback bring-up.
// The stack RX port has no tready, so this block is always ready and never back-pressures.

---
 rtl/udp_rx_payload_checker.sv | 173 +++++++++++++++++
 tb/tb_udp_rx_payload_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_payload_checker.sv
// Always-ready sink for the UDP stack user RX stream: checks payload pattern, tuser length,
// tkeep framing and inter-beat gaps, and keeps saturating loopback statistics.
module udp_rx_payload_checker #(
   parameter int unsigned P_TIMEOUT  = 256,
   parameter logic [7:0]  P_SEQ_INIT = 8'h00
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [63:0] s_axis_tdata,
   input  logic [31:0] s_axis_tuser,
   input  logic [7:0]  s_axis_tkeep,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tvalid,
   input  logic        i_clear,
   output logic        o_pkt_done,
   output logic        o_pkt_ok,
   output logic [3:0]  o_err_flags,
   output logic [31:0] o_pkt_cnt,
   output logic [31:0] o_err_cnt,
   output logic [47:0] o_byte_cnt,
   output logic [7:0]  o_exp_seq
);

   localparam int unsigned TW = $clog2(P_TIMEOUT + 1);

   typedef enum logic [0:0] {StIdle, StData} state_e;

   state_e        state_q, state_d;
   logic [7:0]    seed_q, seed_d;
   logic [15:0]   k_q, k_d;
   logic [15:0]   len_q, len_d;
   logic          err_data_q, err_data_d;
   logic          err_keep_q, err_keep_d;
   logic [TW-1:0] idle_q, idle_d;

   logic          first;
   logic [7:0]    beat_seed;
   logic [15:0]   beat_k;
   logic [15:0]   beat_len;
   logic [15:0]   k_next;
   logic [3:0]    pop;
   logic          beat_data_err;
   logic          beat_keep_err;
   logic          keep_last_ok;
   logic [7:0]    byte_v;
   logic [7:0]    exp_v;

   logic          fin;
   logic [3:0]    fin_flags;
   logic [7:0]    fin_seed;
   logic [48:0]   byte_sum;

   // A beat in IDLE starts a packet: its byte0 becomes the seed the rest is checked against.
   always_comb begin
      first     = (state_q == StIdle);
      beat_seed = first ? s_axis_tdata[63:56] : seed_q;
      beat_k    = first ? 16'd0 : k_q;
      beat_len  = first ? s_axis_tuser[15:0] : len_q;
   end

   always_comb begin
      beat_data_err = 1'b0;
      pop           = 4'd0;
      byte_v        = 8'd0;
      exp_v         = 8'd0;
      for (int j = 0; j < 8; j++) begin
         byte_v = s_axis_tdata[63-8*j -: 8];
         exp_v  = beat_seed + beat_k[7:0] + 8'(j);
         if (s_axis_tkeep[7-j]) begin
            pop = pop + 4'd1;
            if (byte_v != exp_v) beat_data_err = 1'b1;
         end
      end
      if (first && (s_axis_tdata[63:56] != o_exp_seq)) beat_data_err = 1'b1;
      k_next = beat_k + 16'(pop);
   end

   always_comb begin
      case (s_axis_tkeep)
         8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF: keep_last_ok = 1'b1;
         default:                                                 keep_last_ok = 1'b0;
      endcase
      beat_keep_err = s_axis_tlast ? !keep_last_ok : (s_axis_tkeep != 8'hFF);
   end

   // Next-state: packet tracking, timeout and completion decode.
   always_comb begin
      state_d    = state_q;
      seed_d     = seed_q;
      k_d        = k_q;
      len_d      = len_q;
      err_data_d = err_data_q;
      err_keep_d = err_keep_q;
      idle_d     = idle_q;
      fin        = 1'b0;
      fin_flags  = 4'd0;
      fin_seed   = seed_q;
      if (s_axis_tvalid) begin
         idle_d     = '0;
         seed_d     = beat_seed;
         k_d        = k_next;
         len_d      = beat_len;
         err_data_d = (!first && err_data_q) || beat_data_err;
         err_keep_d = (!first && err_keep_q) || beat_keep_err;
         if (s_axis_tlast) begin
            fin       = 1'b1;
            fin_flags = {1'b0, err_keep_d, (k_next != beat_len), err_data_d};
            fin_seed  = beat_seed;
            state_d   = StIdle;
         end else begin
            state_d = StData;
         end
      end else if (state_q == StData) begin
         if (idle_q == TW'(P_TIMEOUT - 1)) begin
            // Length is not judged on an aborted packet; only the timeout and prior errors.
            fin       = 1'b1;
            fin_flags = {1'b1, err_keep_q, 1'b0, err_data_q};
            fin_seed  = seed_q;
            idle_d    = '0;
            state_d   = StIdle;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         state_q    <= StIdle;
         seed_q     <= 8'd0;
         k_q        <= 16'd0;
         len_q      <= 16'd0;
         err_data_q <= 1'b0;
         err_keep_q <= 1'b0;
         idle_q     <= '0;
      end else begin
         state_q    <= state_d;
         seed_q     <= seed_d;
         k_q        <= k_d;
         len_q      <= len_d;
         err_data_q <= err_data_d;
         err_keep_q <= err_keep_d;
         idle_q     <= idle_d;
      end
   end

   assign byte_sum = {1'b0, o_byte_cnt} + 49'(pop);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         o_pkt_done  <= 1'b0;
         o_pkt_ok    <= 1'b0;
         o_err_flags <= 4'd0;
         o_pkt_cnt   <= 32'd0;
         o_err_cnt   <= 32'd0;
         o_byte_cnt  <= 48'd0;
         o_exp_seq   <= P_SEQ_INIT;
      end else begin
         o_pkt_done <= fin;
         if (s_axis_tvalid) begin
            o_byte_cnt <= byte_sum[48] ? '1 : byte_sum[47:0];
         end
         if (fin) begin
            o_pkt_ok    <= (fin_flags == 4'd0);
            o_err_flags <= fin_flags;
            o_exp_seq   <= fin_seed + 8'd1;
            if (o_pkt_cnt != '1) o_pkt_cnt <= o_pkt_cnt + 32'd1;
            if ((fin_flags != 4'd0) && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_udp_rx_payload_checker.sv
// Directed self-checking bench for udp_rx_payload_checker with hand-computed expectations.
module tb_udp_rx_payload_checker;

   localparam int unsigned TIMEOUT = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] tdata;
   logic [31:0] tuser;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        tvalid;
   logic        clr;
   logic        pkt_done;
   logic        pkt_ok;
   logic [3:0]  err_flags;
   logic [31:0] pkt_cnt;
   logic [31:0] err_cnt;
   logic [47:0] byte_cnt;
   logic [7:0]  exp_seq;

   int passed = 0;
   int total  = 0;

   udp_rx_payload_checker #(
      .P_TIMEOUT (TIMEOUT),
      .P_SEQ_INIT(8'h00)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .s_axis_tdata (tdata),
      .s_axis_tuser (tuser),
      .s_axis_tkeep (tkeep),
      .s_axis_tlast (tlast),
      .s_axis_tvalid(tvalid),
      .i_clear      (clr),
      .o_pkt_done   (pkt_done),
      .o_pkt_ok     (pkt_ok),
      .o_err_flags  (err_flags),
      .o_pkt_cnt    (pkt_cnt),
      .o_err_cnt    (err_cnt),
      .o_byte_cnt   (byte_cnt),
      .o_exp_seq    (exp_seq)
   );

   always #5 clk = ~clk;

   // Drives one packet of pattern bytes, one beat per cycle; returns 1 time unit after the
   // edge that captured the final beat, with tvalid dropped.
   task automatic send_pkt(input logic [7:0] seed, input int nbytes, input logic [15:0] len,
                           input int corrupt, input logic [7:0] last_keep, input bit no_last,
                           input bit clr_last);
      int nbeats;
      int rem;
      logic [63:0] d;
      logic [7:0] v;
      logic [7:0] k;
      nbeats = (nbytes + 7) / 8;
      for (int b = 0; b < nbeats; b++) begin
         for (int j = 0; j < 8; j++) begin
            v = seed + 8'(b * 8 + j);
            if (b * 8 + j == corrupt) v = v ^ 8'hFF;
            d[63-8*j -: 8] = v;
         end
         rem = nbytes - b * 8;
         k = (b < nbeats - 1) ? 8'hFF : ~(8'hFF >> rem);
         if (b == nbeats - 1 && last_keep != 8'h00) k = last_keep;
         tdata  = d;
         tkeep  = k;
         tuser  = {16'hABCD, len};
         tlast  = (b == nbeats - 1) && !no_last;
         tvalid = 1'b1;
         clr    = clr_last && (b == nbeats - 1);
         @(posedge clk);
         #1;
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
      clr    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; clr = 1'b0;
      tdata = '0; tuser = '0; tkeep = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      total++;
      if ({pkt_done, pkt_ok, err_flags} !== 6'b0) $display("FAIL reset_status got %b want 000000", {pkt_done, pkt_ok, err_flags});
      else passed++;
      total++;
      if ({pkt_cnt, err_cnt} !== 64'd0) $display("FAIL reset_cnts got %h want 0", {pkt_cnt, err_cnt});
      else passed++;
      total++;
      if ({byte_cnt, exp_seq} !== 56'd0) $display("FAIL reset_bytes_seq got %h want 0", {byte_cnt, exp_seq});
      else passed++;
   endtask

   task automatic test_basic();
      for (int p = 0; p < 3; p++) begin
         send_pkt(8'(p), 64, 16'd64, -1, 8'h00, 1'b0, 1'b0);
         total++;
         if ({pkt_done, pkt_ok, err_flags} !== 6'b110000) $display("FAIL basic_pkt%0d got %b want 110000", p, {pkt_done, pkt_ok, err_flags});
         else passed++;
      end
      @(posedge clk); #1;
      total++;
      if (pkt_done !== 1'b0) $display("FAIL basic_pulse got %b want 0", pkt_done);
      else passed++;
      total++;
      if ({pkt_cnt, err_cnt, byte_cnt, exp_seq} !== {32'd3, 32'd0, 48'd192, 8'h03}) $display("FAIL basic_stats got %0d %0d %0d %h want 3 0 192 03", pkt_cnt, err_cnt, byte_cnt, exp_seq);
      else passed++;
   endtask

   task automatic test_len_keep();
      send_pkt(8'h03, 13, 16'd13, -1, 8'h00, 1'b0, 1'b0);
      total++;
      if ({pkt_done, pkt_ok, err_flags, byte_cnt} !== {6'b110000, 48'd205}) $display("FAIL len13_ok got %b %0d want 110000 205", {pkt_done, pkt_ok, err_flags}, byte_cnt);
      else passed++;
      send_pkt(8'h04, 13, 16'd13, -1, 8'hF4, 1'b0, 1'b0);
      total++;
      if ({pkt_done, pkt_ok, err_flags} !== 6'b100100) $display("FAIL keep_f4 got %b want 100100", {pkt_done, pkt_ok, err_flags});
      else passed++;
      total++;
      if ({err_cnt, byte_cnt, exp_seq} !== {32'd1, 48'd218, 8'h05}) $display("FAIL keep_f4_stats got %0d %0d %h want 1 218 05", err_cnt, byte_cnt, exp_seq);
      else passed++;
   endtask

   task automatic test_corrupt();
      send_pkt(8'h05, 64, 16'd64, 20, 8'h00, 1'b0, 1'b0);
      total++;
      if ({pkt_done, pkt_ok, err_flags, err_cnt, exp_seq} !== {6'b100001, 32'd2, 8'h06}) $display("FAIL corrupt got %b %0d %h want 100001 2 06", {pkt_done, pkt_ok, err_flags}, err_cnt, exp_seq);
      else passed++;
   endtask

   task automatic test_resync();
      send_pkt(8'h09, 16, 16'd16, -1, 8'h00, 1'b0, 1'b0);
      total++;
      if ({pkt_done, pkt_ok, err_flags, exp_seq} !== {6'b100001, 8'h0A}) $display("FAIL seed_skip got %b %h want 100001 0a", {pkt_done, pkt_ok, err_flags}, exp_seq);
      else passed++;
      send_pkt(8'h0A, 16, 16'd16, -1, 8'h00, 1'b0, 1'b0);
      total++;
      if ({pkt_done, pkt_ok, err_flags, exp_seq, err_cnt} !== {6'b110000, 8'h0B, 32'd3}) $display("FAIL resync_ok got %b %h %0d want 110000 0b 3", {pkt_done, pkt_ok, err_flags}, exp_seq, err_cnt);
      else passed++;
   endtask

   task automatic test_length_timeout();
      int waited;
      send_pkt(8'h0B, 96, 16'd100, -1, 8'h00, 1'b0, 1'b0);
      total++;
      if ({pkt_done, pkt_ok, err_flags, byte_cnt} !== {6'b100010, 48'd410}) $display("FAIL short_len got %b %0d want 100010 410", {pkt_done, pkt_ok, err_flags}, byte_cnt);
      else passed++;
      send_pkt(8'h0C, 24, 16'd64, -1, 8'h00, 1'b1, 1'b0);
      waited = 0;
      for (int i = 1; i <= TIMEOUT + 8; i++) begin
         @(posedge clk); #1;
         if (pkt_done) begin
            waited = i;
            break;
         end
      end
      total++;
      if (waited !== int'(TIMEOUT)) $display("FAIL timeout_latency got %0d want %0d", waited, TIMEOUT);
      else passed++;
      total++;
      if ({pkt_ok, err_flags, exp_seq, err_cnt, pkt_cnt} !== {5'b01000, 8'h0D, 32'd5, 32'd10}) $display("FAIL timeout_flags got %b %h %0d %0d want 01000 0d 5 10", {pkt_ok, err_flags}, exp_seq, err_cnt, pkt_cnt);
      else passed++;
      send_pkt(8'h0D, 8, 16'd8, -1, 8'h00, 1'b0, 1'b0);
      total++;
      if ({pkt_done, pkt_ok, err_flags, byte_cnt} !== {6'b110000, 48'd442}) $display("FAIL after_timeout got %b %0d want 110000 442", {pkt_done, pkt_ok, err_flags}, byte_cnt);
      else passed++;
   endtask

   task automatic test_clear_back_to_back();
      send_pkt(8'h0E, 16, 16'd16, -1, 8'h00, 1'b0, 1'b1);
      total++;
      if ({pkt_done, pkt_cnt, err_cnt, byte_cnt, exp_seq} !== {1'b0, 32'd0, 32'd0, 48'd0, 8'h00}) $display("FAIL clear got %b %0d %0d %0d %h want 0 0 0 0 00", pkt_done, pkt_cnt, err_cnt, byte_cnt, exp_seq);
      else passed++;
      for (int p = 0; p < 4; p++) begin
         send_pkt(8'(p), 8, 16'd8, -1, 8'h00, 1'b0, 1'b0);
         total++;
         if ({pkt_done, pkt_ok, err_flags} !== 6'b110000) $display("FAIL b2b_pkt%0d got %b want 110000", p, {pkt_done, pkt_ok, err_flags});
         else passed++;
      end
      send_pkt(8'h04, 1, 16'd1, -1, 8'h00, 1'b0, 1'b0);
      total++;
      if ({pkt_done, pkt_ok, err_flags, pkt_cnt, byte_cnt, exp_seq} !== {6'b110000, 32'd5, 48'd33, 8'h05}) $display("FAIL b2b_stats got %b %0d %0d %h want 110000 5 33 05", {pkt_done, pkt_ok, err_flags}, pkt_cnt, byte_cnt, exp_seq);
      else passed++;
   endtask

   task automatic test_reset_mid();
      send_pkt(8'h05, 16, 16'd64, -1, 8'h00, 1'b1, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({pkt_done, pkt_cnt, byte_cnt, exp_seq} !== {1'b0, 32'd0, 48'd0, 8'h00}) $display("FAIL reset_mid got %b %0d %0d %h want 0 0 0 00", pkt_done, pkt_cnt, byte_cnt, exp_seq);
      else passed++;
      send_pkt(8'h00, 16, 16'd16, -1, 8'h00, 1'b0, 1'b0);
      total++;
      if ({pkt_done, pkt_ok, err_flags, pkt_cnt} !== {6'b110000, 32'd1}) $display("FAIL reset_mid_next got %b %0d want 110000 1", {pkt_done, pkt_ok, err_flags}, pkt_cnt);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_keep();
      test_corrupt();
      test_resync();
      test_length_timeout();
      test_clear_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
